// File: rtl/cim_ctl_pkg.sv
// Shared types and sizing for the cascaded-integrator frame controller.
package cim_ctl_pkg;

  localparam int unsigned DwDefault = 32;
  localparam int unsigned NwDefault = 16;
  localparam int unsigned PwDefault = 16;

  typedef enum logic [1:0] {
    StEmpty,
    StFill,
    StFull
  } buf_state_e;

  // Shortest strobe interval that still lets the chain finish shifting a frame.
  function automatic int unsigned min_period(int unsigned nw);
    return nw + 4;
  endfunction

endpackage

// File: rtl/cim_sample_timer.sv
// Period counter with minimum-interval clamp; issues the registered sample strobe.
module cim_sample_timer
  import cim_ctl_pkg::*;
#(
  parameter int unsigned Nw = NwDefault,
  parameter int unsigned Pw = PwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic [Pw-1:0] period_i,
  output logic          sample_o
);

  localparam logic [Pw-1:0] MinPeriod = Pw'(min_period(Nw));

  logic [Pw-1:0] cnt_q;
  logic [Pw-1:0] eff;
  logic          sample_q;

  assign eff = (period_i < MinPeriod) ? MinPeriod : period_i;

  // Counter sits at zero out of reset, so the first enabled cycle strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      sample_q <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      if (enable_i) begin
        if (cnt_q == '0) begin
          sample_q <= 1'b1;
          cnt_q    <= eff - Pw'(1);
        end else begin
          cnt_q <= cnt_q - Pw'(1);
        end
      end
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/cim_frame_ctl.sv
// Strobes the integrator chain, captures one shifted-out frame and streams it to the host.
module cim_frame_ctl
  import cim_ctl_pkg::*;
#(
  parameter int unsigned Dw = DwDefault,
  parameter int unsigned Nw = NwDefault,
  parameter int unsigned Pw = PwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic [Pw-1:0] period_i,
  output logic          sample_o,
  input  logic [Dw-1:0] sr_in_i,
  input  logic          sr_val_in_i,
  output logic [Dw-1:0] rd_data_o,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic          rd_last_o,
  output logic [15:0]   frame_cnt_o,
  output logic          overrun_o,
  input  logic          overrun_clr_i
);

  localparam int unsigned   Iw      = (Nw > 1) ? $clog2(Nw) : 1;
  localparam logic [Iw-1:0] LastIdx = Iw'(Nw - 1);

  buf_state_e    state_q;
  logic [Iw-1:0] wi_q, ri_q, ri_nxt;
  logic [Dw-1:0] buf_q [Nw];
  logic [Dw-1:0] rd_data_q;
  logic          rd_valid_q, rd_last_q, overrun_q;
  logic [15:0]   frame_cnt_q;
  logic          sample;
  logic          wr_en, rd_fire, rd_done, drop;

  cim_sample_timer #(
    .Nw(Nw),
    .Pw(Pw)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable_i(enable_i),
    .period_i(period_i),
    .sample_o(sample)
  );

  assign wr_en   = (state_q == StFill) && sr_val_in_i;
  assign rd_fire = rd_valid_q && rd_ready_i;
  assign rd_done = rd_fire && (ri_q == LastIdx);
  assign ri_nxt  = ri_q + Iw'(1);
  // A strobe finding the buffer busy drops its frame, unless the last word leaves now.
  assign drop    = sample && ((state_q == StFill) || ((state_q == StFull) && !rd_done));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[wi_q] <= sr_in_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      wi_q        <= '0;
      ri_q        <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_q <= 1'b0;
      end
      unique case (state_q)
        StEmpty: begin
          if (sample) begin
            state_q <= StFill;
            wi_q    <= '0;
          end
        end
        StFill: begin
          if (sr_val_in_i) begin
            wi_q <= wi_q + Iw'(1);
            if (wi_q == LastIdx) begin
              state_q    <= StFull;
              ri_q       <= '0;
              rd_valid_q <= 1'b1;
              rd_data_q  <= (Nw == 1) ? sr_in_i : buf_q[0];
              rd_last_q  <= (Nw == 1);
            end
          end
        end
        StFull: begin
          if (rd_done) begin
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= sample ? StFill : StEmpty;
            wi_q        <= '0;
          end else if (rd_fire) begin
            ri_q      <= ri_nxt;
            rd_data_q <= buf_q[ri_nxt];
            rd_last_q <= (ri_nxt == LastIdx);
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign sample_o    = sample;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign rd_last_o   = rd_last_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_cim_frame_ctl.sv
// Bench for cim_frame_ctl: queue-based reference model, chain emulator, directed corner cases.
module tb_cim_frame_ctl;

  localparam int NW   = 16;
  localparam int DW   = 32;
  localparam int PW   = 16;
  localparam int MINP = NW + 4;

  typedef struct {
    logic [15:0] period;
    int          interval;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [PW-1:0] period = 16'd100;
  logic          sample;
  logic [DW-1:0] sr_in = '0;
  logic          sr_val = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          rd_last;
  logic [15:0]   frame_cnt;
  logic          overrun;
  logic          overrun_clr = 1'b0;

  always #5 clk = ~clk;

  cim_frame_ctl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable),
    .period_i     (period),
    .sample_o     (sample),
    .sr_in_i      (sr_in),
    .sr_val_in_i  (sr_val),
    .rd_data_o    (rd_data),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_last_o    (rd_last),
    .frame_cnt_o  (frame_cnt),
    .overrun_o    (overrun),
    .overrun_clr_i(overrun_clr)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: strobe schedule as a count of enabled edges, frames as word queues.
  bit          m_coll;
  logic [31:0] m_fill[$];
  logic [31:0] m_out[$];
  int          m_fc, m_dropped, m_en_edges, m_eff;
  bit          m_ov, m_samp;

  // Chain emulator and delivered-word log.
  int          ch_idx = NW;
  int          ch_start = 0;
  logic [31:0] ch_base = '0;
  int          nstrobes = 0;
  logic [31:0] got_d[$];
  bit          got_l[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic model_reset();
    m_coll = 0;
    m_fill.delete();
    m_out.delete();
    m_fc = 0;
    m_ov = 0;
    m_samp = 0;
    m_en_edges = 0;
    m_eff = 1;
  endtask

  task automatic model_edge(input logic en_b, input logic [PW-1:0] per_b, input logic rdy_b,
                            input logic sv_b, input logic [31:0] sd_b, input logic clr_b);
    bit coll_pre, busy, fin, drop;
    coll_pre = m_coll;
    busy = (m_out.size() != 0);
    fin = 0;
    drop = 0;
    if (busy && rdy_b) begin
      void'(m_out.pop_front());
      if (m_out.size() == 0) begin
        fin = 1;
        m_fc++;
      end
    end
    if (coll_pre && sv_b) begin
      m_fill.push_back(sd_b);
      if (m_fill.size() == NW) begin
        m_out = m_fill;
        m_fill.delete();
        m_coll = 0;
      end
    end
    if (m_samp) begin
      if (coll_pre || (busy && !fin)) drop = 1;
      else begin
        m_coll = 1;
        m_fill.delete();
      end
    end
    if (drop) begin
      m_ov = 1;
      m_dropped++;
    end else if (clr_b) m_ov = 0;
    m_samp = 0;
    if (en_b) begin
      m_en_edges++;
      if (m_en_edges >= m_eff) begin
        m_samp = 1;
        m_en_edges = 0;
        m_eff = (int'(per_b) < MINP) ? MINP : int'(per_b);
      end
    end
  endtask

  task automatic step();
    logic en_b, rdy_b, sv_b, clr_b, rst_b, v_b, l_b;
    logic [PW-1:0] per_b;
    logic [31:0] sd_b, d_b;
    en_b = enable; rdy_b = rd_ready; sv_b = sr_val; clr_b = overrun_clr; rst_b = rst_n;
    v_b = rd_valid; l_b = rd_last; per_b = period; sd_b = sr_in; d_b = rd_data;
    @(posedge clk);
    #1;
    cyc++;
    if (v_b && rdy_b) begin
      got_d.push_back(d_b);
      got_l.push_back(l_b);
    end
    if (!rst_b) model_reset();
    else model_edge(en_b, per_b, rdy_b, sv_b, sd_b, clr_b);
    chk("sample", 32'(sample), 32'(m_samp));
    chk("rd_valid", 32'(rd_valid), 32'(m_out.size() != 0));
    if (m_out.size() != 0) begin
      chk("rd_data", rd_data, m_out[0]);
      chk("rd_last", 32'(rd_last), 32'(m_out.size() == 1));
    end
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fc[15:0]));
    chk("overrun", 32'(overrun), 32'(m_ov));
    if (sample) begin
      ch_idx = 0;
      ch_start = cyc + 2;
      ch_base = 32'h1000 + 32'(nstrobes) * 32'h10000;
      nstrobes++;
    end
    if (ch_idx < NW && cyc >= ch_start) begin
      sr_val = 1'b1;
      sr_in = ch_base + 32'(ch_idx);
      ch_idx++;
    end else begin
      sr_val = 1'b0;
      sr_in = $urandom;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_strobe(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sample) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) fail_now("strobe_wait");
  endtask

  task automatic check_frame(input string name, input logic [31:0] base);
    chk({name, "_count"}, 32'(got_d.size()), 32'(NW));
    for (int i = 0; i < NW && i < got_d.size(); i++) begin
      chk($sformatf("%s_w%0d", name, i), got_d[i], base + 32'(i));
      chk($sformatf("%s_last%0d", name, i), 32'(got_l[i]), 32'(i == NW - 1));
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_sample"}, 32'(sample), 32'd0);
    chk({name, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({name, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({name, "_rd_data"}, rd_data, 32'd0);
    chk({name, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    chk({name, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int s0, s1, a, b, t, fcb, ns0, d0, e;
    logic [15:0] fc0;
    logic [31:0] cap;

    vecs[0] = '{16'd5, 20};
    vecs[1] = '{16'd0, 20};
    vecs[2] = '{16'd19, 20};
    vecs[3] = '{16'd20, 20};
    vecs[4] = '{16'd21, 21};
    vecs[5] = '{16'd64, 64};
    vecs[6] = '{16'd100, 100};
    m_dropped = 0;
    model_reset();

    // Reset state and first strobe.
    run(3);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    run(2);
    period = 16'd100;
    enable = 1'b1;
    rd_ready = 1'b1;
    e = cyc + 1;
    wait_strobe(5, s0);
    chk("first_strobe_cycle", 32'(s0), 32'(e));

    // Basic frame.
    got_d.delete(); got_l.delete();
    run(60);
    check_frame("basic", 32'h1000);
    chk("basic_frame_cnt", 32'(frame_cnt), 32'd1);
    wait_strobe(100, s1);
    chk("basic_interval", 32'(s1 - s0), 32'd100);

    // Clamp table: each period is latched at one strobe and timed to the next.
    for (int k = 0; k < 7; k++) begin
      period = vecs[k].period;
      wait_strobe(400, a);
      wait_strobe(400, b);
      chk($sformatf("interval_p%0d", vecs[k].period), 32'(b - a), 32'(vecs[k].interval));
    end

    // Backpressure across two strobes.
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("ovr_clear", 32'(overrun), 32'd0);
    wait_strobe(200, a);
    cap = ch_base;
    fcb = m_fc;
    rd_ready = 1'b0;
    wait_strobe(200, a);
    wait_strobe(200, a);
    run(3);
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_valid", 32'(rd_valid), 32'd1);
    chk("bp_held_word0", rd_data, cap);
    got_d.delete(); got_l.delete();
    rd_ready = 1'b1;
    run(20);
    check_frame("bp", cap);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'(16'(fcb + 1)));
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    chk("bp_ovr_clr", 32'(overrun), 32'd0);

    // Final handshake lands on the strobe cycle.
    rd_ready = 1'b0;
    wait_strobe(200, a);
    cap = ch_base;
    fcb = m_fc;
    t = a + 100;
    got_d.delete(); got_l.delete();
    while (cyc < t) begin
      rd_ready = (cyc >= t - 15);
      step();
    end
    chk("coinc_strobe", 32'(sample), 32'd1);
    rd_ready = 1'b1;
    ns0 = 0;
    b = 0;
    step();
    check_frame("coinc_a", cap);
    chk("coinc_overrun", 32'(overrun), 32'd0);
    chk("coinc_frame_cnt", 32'(frame_cnt), 32'(16'(fcb + 1)));
    cap = 32'h1000 + 32'(nstrobes - 1) * 32'h10000;
    got_d.delete(); got_l.delete();
    run(40);
    check_frame("coinc_b", cap);

    // Enable dropped mid-frame: capture and drain complete, strobes stop.
    wait_strobe(200, a);
    cap = ch_base;
    run(3);
    enable = 1'b0;
    ns0 = nstrobes;
    got_d.delete(); got_l.delete();
    run(150);
    chk("en_off_no_strobe", 32'(nstrobes), 32'(ns0));
    check_frame("en_off", cap);
    enable = 1'b1;

    // Random stall with random overrun clears.
    period = 16'd64;
    ns0 = nstrobes;
    d0 = m_dropped;
    fc0 = frame_cnt;
    for (int i = 0; i < 20000 && (nstrobes - ns0) < 200; i++) begin
      rd_ready = 1'($urandom % 2);
      overrun_clr = (($urandom % 8) == 0);
      step();
    end
    if ((nstrobes - ns0) < 200) fail_now("random_strobes");
    enable = 1'b0;
    overrun_clr = 1'b0;
    rd_ready = 1'b1;
    run(80);
    chk("rand_balance", 32'(int'(frame_cnt - fc0) + (m_dropped - d0)), 32'(nstrobes - ns0));

    // Asynchronous reset after seven gated words.
    enable = 1'b1;
    wait_strobe(200, a);
    for (int i = 0; i < 30 && ch_idx < 7; i++) step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midfill");
    model_reset();
    run(20);
    rst_n = 1'b1;
    e = cyc + 1;
    wait_strobe(5, a);
    chk("post_rst_first_strobe", 32'(a), 32'(e));
    cap = ch_base;
    got_d.delete(); got_l.delete();
    run(40);
    check_frame("post_rst", cap);
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cim_frame_ctl.md
# cim_frame_ctl

Sequencer and readout buffer for the 16-channel cascaded-integrator multiplexor chain. It issues the periodic `sample` strobe that snapshots all double-integrator outputs. It collects the 16 words the chain then shifts out on its data/gate pair into a one-frame buffer. It presents that frame to the host side over a valid/ready stream. It sits between the chain's `sample`/`sr_out`/`sr_val` pins and the local-bus or DMA reader.

## Interface
- `dw`, 32, width of chain output words and of `rd_data`
- `nw`, 16, words per frame (8 mixers × cos/sin)
- `pw`, 16, width of the period register
- `clk`  in  1  single system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  run sampling; 0 freezes the period counter
- `period`  in  pw  sample interval in clk cycles; latched at each strobe
- `sample`  out  1  one-cycle snapshot strobe to the chain
- `sr_in`  in  dw  chain data (`sr_out` of the chain)
- `sr_val_in`  in  1  chain gate (`sr_val` of the chain)
- `rd_data`  out  dw  buffered word
- `rd_valid`  out  1  `rd_data` valid
- `rd_ready`  in  1  reader accepts the word
- `rd_last`  out  1  qualifies the final word (index nw-1) of a frame
- `frame_cnt`  out  16  frames fully delivered, wraps at 2^16
- `overrun`  out  1  sticky: at least one frame dropped
- `overrun_clr`  in  1  clears `overrun`

## Operation
- **Period counter**
  - `cnt` loads `eff-1` and counts down while `enable`=1.
  - At `cnt`=0 with `enable`=1, `sample` pulses and `cnt` reloads.
  - `eff = max(period, MIN_PERIOD)`, where `MIN_PERIOD = nw+4`. This guarantees the shift-out completes before the next strobe.
  - `period` is sampled only at reload. Mid-interval changes take effect at the next interval.
- **Buffer FSM**
  - EMPTY: a `sample` pulse → FILL, with write index `wi`=0.
  - FILL: each cycle with `sr_val_in`=1 writes `sr_in` to `buf[wi]` and increments `wi`. The write at `wi`=nw-1 → FULL, with read index `ri`=0.
  - FULL: `rd_valid`=1 and `rd_data`=`buf[ri]`; `rd_last`=(`ri`==nw-1).
  - On `rd_valid & rd_ready`, `ri` increments. The handshake at `ri`=nw-1 → EMPTY and increments `frame_cnt`.
- **Drop rule**
  - A `sample` pulse in FILL or FULL sets `overrun`. The new frame's words are ignored.
  - The buffer and read stream are unaffected.
  - `sample` is never suppressed, so integration intervals stay uniform.
- **Simultaneous events**
  - The final read handshake in the same cycle as `sample`: the frame is accepted and the FSM goes straight to FILL with `wi`=0. No overrun.
  - `overrun_clr` in the same cycle as a drop: the set wins.
- **Gate outside FILL:** `sr_val_in` outside FILL is ignored.
- **Enable deasserted mid-frame:** FILL still completes and FULL still drains. Only the strobe stops.
- **Unreachable cases:**
  - `sr_val_in` beyond nw words in a FILL cannot occur because FILL exits at nw.
  - Fewer than nw words before the next strobe also cannot occur, given `MIN_PERIOD`.

## Timing
- **Reset values:** `sample`=0, `rd_valid`=0, `rd_last`=0, `rd_data`=0, `frame_cnt`=0, `overrun`=0. FSM=EMPTY and `cnt`=0.
  - The first strobe comes on the first cycle with `enable`=1 after reset.
- **Outputs are registered.** `sample` is registered; the chain snapshots on the cycle `sample` is high.
- **Write to read latency:** `rd_valid` rises on the cycle after the nw-th gated word is written.
- **Read throughput:**
  - One word per cycle while `rd_ready`=1.
  - `rd_data`, `rd_last` and `rd_valid` hold stable while `rd_valid & !rd_ready`.
- **Overrun timing:** `overrun` sets the cycle after the offending `sample`.
- **Mid-operation reset:** async assert clears everything immediately. A frame in progress is discarded and the chain is not notified.

## Structure
- Package `cim_ctl_pkg` holds:
  - the FSM state enum (EMPTY, FILL, FULL);
  - `MIN_PERIOD` as nw+4 in function form;
  - default `nw`/`dw`.
- Sub-module `cim_sample_timer` holds the period counter, clamp and strobe (ports `clk`, `rst_n`, `enable`, `period`, `sample`).
- The buffer is an nw×dw register array or small distributed RAM, with the FSM in the top level.

## Test plan
- **Basic frame:** `period`=100, `enable`=1, chain model emits words 0x1000+i with gate over 16 cycles starting 2 cycles after `sample`; `rd_ready`=1.
  - Expect `sample` every 100 cycles.
  - Expect 16 words 0x1000..0x100F.
  - Expect `rd_last` on 0x100F and `frame_cnt`=1.
- **Clamp:** `period`=5.
  - Expect `sample` every 20 cycles (nw+4).
- **Backpressure/drop:** hold `rd_ready`=0 across two strobes.
  - Expect `overrun`=1 and the buffer still holding frame 1.
  - After release, expect frame 1 intact and `frame_cnt`=1, not 2.
- **Coincidence:** time the last read handshake exactly on a `sample` cycle.
  - Expect no overrun and the next frame captured completely.
- **Random stall:** random `rd_ready` (50%) with `period`=64 over 200 frames.
  - Expect data held stable during stalls and every delivered frame in order.
  - Expect `frame_cnt` + dropped = strobes.
- **Reset mid-FILL:** pulse `rst_n` low after 7 gated words.
  - Expect all outputs at reset values.
  - After re-enable, expect first strobe on the first enabled cycle and a clean frame.
